// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
// Holds the funct3 operation codes, the FSM state type and the special-case result constants.
package muldiv_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_MUL    = 3'b000;
    localparam op_t OP_MULH   = 3'b001;
    localparam op_t OP_MULHSU = 3'b010;
    localparam op_t OP_MULHU  = 3'b011;
    localparam op_t OP_DIV    = 3'b100;
    localparam op_t OP_DIVU   = 3'b101;
    localparam op_t OP_REM    = 3'b110;
    localparam op_t OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    function automatic logic is_div(op_t o);
        return o[2];
    endfunction

    function automatic logic is_rem(op_t o);
        return o[2] & o[1];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle,
// sharing a single adder/subtractor and a 64-bit accumulator.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] num1,
    input  logic [XLEN-1:0] num2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rlt
);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [XLEN-1:0]   x_q, x_d;       // multiplicand / dividend magnitude
    logic [XLEN-1:0]   y_q, y_d;       // multiplier / divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   rlt_q, rlt_d;

    // Operand conditioning at start
    logic            sgn1, sgn2, neg1, neg2, start_neg;
    logic [XLEN-1:0] mag1, mag2, special_rlt;
    logic            div0, ovf, special;

    always_comb begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        case (op)
            OP_MULH, OP_DIV, OP_REM: begin
                sgn1 = 1'b1;
                sgn2 = 1'b1;
            end
            OP_MULHSU: sgn1 = 1'b1;
            default: ;
        endcase
    end

    assign neg1      = sgn1 & num1[XLEN-1];
    assign neg2      = sgn2 & num2[XLEN-1];
    assign mag1      = neg1 ? (~num1 + 1'b1) : num1;
    assign mag2      = neg2 ? (~num2 + 1'b1) : num2;
    assign start_neg = is_rem(op) ? neg1 : (neg1 ^ neg2);

    assign div0    = is_div(op) && (num2 == '0);
    assign ovf     = ((op == OP_DIV) || (op == OP_REM)) && (num1 == INT_MIN) && (num2 == '1);
    assign special = div0 | ovf;

    always_comb begin
        if (div0) begin
            special_rlt = is_rem(op) ? num1 : DIV0_QUO;
        end else begin
            special_rlt = is_rem(op) ? '0 : INT_MIN;
        end
    end

    // Shared adder: adds the multiplicand in multiply mode, trial-subtracts the divisor in divide mode
    logic            div_mode, nonneg;
    logic [XLEN:0]   opa, opb;
    logic [XLEN+1:0] sum;
    logic [2*XLEN-1:0] step_acc;

    assign div_mode = is_div(op_q);
    assign opa = div_mode ? {acc_q[2*XLEN-1:XLEN], x_q[XLEN-1]} : {1'b0, acc_q[2*XLEN-1:XLEN]};
    assign opb = div_mode ? {1'b0, y_q} : (y_q[0] ? {1'b0, x_q} : '0);
    assign sum = {1'b0, opa} + {1'b0, opb ^ {(XLEN+1){div_mode}}} + {{(XLEN+1){1'b0}}, div_mode};
    assign nonneg = sum[XLEN+1];

    always_comb begin
        if (div_mode) begin
            step_acc = {(nonneg ? sum[XLEN-1:0] : opa[XLEN-1:0]), acc_q[XLEN-2:0], nonneg};
        end else begin
            step_acc = {sum[XLEN:0], acc_q[XLEN-1:1]};
        end
    end

    // Sign fix and result selection from the final iteration's accumulator
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_rlt;

    assign prod_fix = neg_q ? -step_acc : step_acc;
    assign quo_fix  = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    assign rem_fix  = neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];

    always_comb begin
        case (op_q)
            OP_MUL:                        final_rlt = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_rlt = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_rlt = quo_fix;
            default:                       final_rlt = rem_fix;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = special ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == 5'd31) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
        rlt  = rlt_q;
    end

    // Datapath next state
    always_comb begin
        op_d  = op_q;
        x_d   = x_q;
        y_d   = y_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        neg_d = neg_q;
        rlt_d = rlt_q;
        if (!flush) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d  = op;
                        x_d   = mag1;
                        y_d   = mag2;
                        acc_d = '0;
                        cnt_d = '0;
                        neg_d = start_neg;
                        if (special) rlt_d = special_rlt;
                    end
                end
                S_CALC: begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + 5'd1;
                    if (div_mode) begin
                        x_d = {x_q[XLEN-2:0], 1'b0};
                    end else begin
                        y_d = {1'b0, y_q[XLEN-1:1]};
                    end
                    if (cnt_q == 5'd31) rlt_d = final_rlt;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= OP_MUL;
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
            rlt_q <= '0;
        end else begin
            op_q  <= op_d;
            x_q   <= x_d;
            y_q   <= y_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            neg_q <= neg_d;
            rlt_q <= rlt_d;
        end
    end

endmodule
